// File: rtl/of_stage_skid_latch.sv
// OF->EX pipeline stage: valid/ready handshake backed by a two-entry skid
// buffer. The main entry drives EX; the skid entry catches the one transfer
// accepted while EX stalls. When main is empty the stage presents a NOP
// bubble, and bubbles taken by EX are counted.
module of_stage_skid_latch #(
   parameter int          INST_W   = 32,
   parameter int          CTRL_W   = 22,
   parameter int          DATA_W   = 224,
   parameter logic [31:0] NOP_INST = 32'h68000000,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t m_q, s_q, in_e;
   logic   m_v, s_v;
   logic   in_xfer, out_xfer;

   assign in_e     = '{inst: in_inst, ctrl: in_ctrl, data: in_data};
   // in_ready comes straight from the skid-valid flop, so EX stall never
   // propagates combinationally to OF.
   assign in_ready = !s_v;
   assign in_xfer  = in_valid && !s_v;
   assign out_xfer = m_v && out_ready;

   // Main/skid entry update; flush beats everything, payload is kept on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
         m_q <= '0;
         s_q <= '0;
      end else if (flush) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
      end else if (out_xfer && s_v) begin
         m_q <= s_q;
         s_v <= 1'b0;
      end else if (out_xfer || !m_v) begin
         if (in_xfer) begin
            m_q <= in_e;
            m_v <= 1'b1;
         end else begin
            m_v <= 1'b0;
         end
      end else if (in_xfer) begin
         s_q <= in_e;
         s_v <= 1'b1;
      end
   end

   // Saturating count of bubbles actually taken by EX (flush cycles excluded).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (!m_v && out_ready && !flush && (bubble_cnt != {CNT_W{1'b1}}))
         bubble_cnt <= bubble_cnt + 1'b1;
   end

   // Bubble injection: fixed NOP word and zero control when main is empty.
   always_comb begin
      out_valid = m_v;
      out_inst  = m_v ? m_q.inst : INST_W'(NOP_INST);
      out_ctrl  = m_v ? m_q.ctrl : '0;
      out_data  = m_q.data;
   end

endmodule

// File: tb/tb_of_stage_skid_latch.sv
// Bench for of_stage_skid_latch: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of a 2-deep FIFO stage.
module tb_of_stage_skid_latch;
   localparam int          INST_W = 32;
   localparam int          CTRL_W = 22;
   localparam int          DATA_W = 224;
   localparam logic [31:0] NOP    = 32'h68000000;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n, flush, in_valid, out_ready;
   logic [INST_W-1:0] in_inst;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic in_ready, out_valid, in_ready2, out_valid2;
   logic [INST_W-1:0] out_inst, out_inst2;
   logic [CTRL_W-1:0] out_ctrl, out_ctrl2;
   logic [DATA_W-1:0] out_data, out_data2;
   logic [15:0] bubble_cnt;
   logic [1:0]  bubble_cnt2;

   always #5 clk = ~clk;

   of_stage_skid_latch dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_ctrl(out_ctrl), .out_data(out_data),
      .bubble_cnt(bubble_cnt));

   of_stage_skid_latch #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_inst(in_inst), .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid2),
      .out_ready(out_ready), .out_inst(out_inst2), .out_ctrl(out_ctrl2), .out_data(out_data2),
      .bubble_cnt(bubble_cnt2));

   // Reference model: a FIFO of at most two accepted instructions.
   ent_t              q[$];
   logic [DATA_W-1:0] m_last;
   int                bcnt;
   bit                last_acc;
   int                tests = 0;
   int                fails = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_last   = '0;
      bcnt     = 0;
      last_acc = 1'b0;
   endtask

   task automatic check();
      logic [INST_W-1:0] ei;
      logic [CTRL_W-1:0] ec;
      ei = (q.size() > 0) ? q[0].inst : NOP;
      ec = (q.size() > 0) ? q[0].ctrl : '0;
      chk("out_valid",  256'(out_valid),  256'(q.size() > 0));
      chk("in_ready",   256'(in_ready),   256'(q.size() < 2));
      chk("out_inst",   256'(out_inst),   256'(ei));
      chk("out_ctrl",   256'(out_ctrl),   256'(ec));
      chk("out_data",   256'(out_data),   256'(m_last));
      chk("bubble16",   256'(bubble_cnt), 256'((bcnt > 65535) ? 65535 : bcnt));
      chk("bubble2sat", 256'(bubble_cnt2), 256'((bcnt > 3) ? 3 : bcnt));
      chk("dut2_inst",  256'(out_inst2),  256'(ei));
   endtask

   // One clock: model consumes the pre-edge inputs, then outputs are checked.
   task automatic tick();
      ent_t cur;
      bit   acc, oacc;
      @(posedge clk);
      if (rst_n) begin
         cur  = '{inst: in_inst, ctrl: in_ctrl, data: in_data};
         acc  = in_valid && (q.size() < 2);
         oacc = (q.size() > 0) && out_ready;
         if (q.size() == 0 && out_ready && !flush) bcnt++;
         if (flush) q.delete();
         else begin
            if (oacc) void'(q.pop_front());
            if (acc)  q.push_back(cur);
         end
         if (q.size() > 0) m_last = q[0].data;
         last_acc = acc;
      end else begin
         last_acc = 1'b0;
      end
      #1;
      check();
   endtask

   task automatic drive(input bit v, input logic [31:0] inst);
      in_valid = v;
      in_inst  = inst;
      in_ctrl  = CTRL_W'($urandom);
      for (int k = 0; k < 7; k++) in_data[k*32 +: 32] = $urandom;
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'h0000_0055);
      #12;
      check();                                   // reset values, in_valid held
      @(posedge clk); #1 rst_n = 1'b1;
      tick();                                    // held input loads at first edge
      drive(1'b0, 32'h0); out_ready = 1'b1;
      tick(); tick();

      // Streaming 1..8
      for (int i = 1; i <= 8; i++) begin drive(1'b1, i); tick(); end
      drive(1'b0, 0); tick(); tick();

      // Stall: A main, B skid, C held until released
      out_ready = 1'b0;
      drive(1'b1, 32'hA); tick();
      drive(1'b1, 32'hB); tick();
      drive(1'b1, 32'hC); tick(); tick(); tick();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (last_acc) drive(1'b0, 0);
      end

      // Flush with two entries and D on the input
      out_ready = 1'b0;
      drive(1'b1, 32'hA1); tick();
      drive(1'b1, 32'hB1); tick();
      drive(1'b1, 32'hD1); flush = 1'b1; tick();
      flush = 1'b0; drive(1'b0, 0); tick(); tick();
      out_ready = 1'b1; tick();

      // Bubble counting / 2-bit saturation
      for (int i = 0; i < 6; i++) tick();

      // Random traffic
      drive(1'b0, 0);
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || last_acc) drive(($urandom % 4) != 0, $urandom);
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 16) == 0;
         tick();
      end
      flush = 1'b0;

      // Asynchronous reset mid-cycle while holding two entries
      out_ready = 1'b0;
      drive(1'b1, 32'hE1); tick();
      drive(1'b1, 32'hE2); tick();
      drive(1'b0, 0);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check();
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
